router_pkt_gen: RTL

ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_pkt_lfsr_par.sv | 54 +++++
 rtl/router_pkt_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet generator.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [1:0] DEST_ILLEGAL  = 2'b11;
  localparam int         MAX_LEN       = 63;
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;  // bits 7,5,4,3
  localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

  function automatic logic start_legal(input logic [1:0] dest,
                                       input logic [5:0] len,
                                       input int          max_len);
    return (dest != DEST_ILLEGAL) && (len != 6'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/router_pkt_lfsr_par.sv
// Payload LFSR plus running XOR of every byte emitted so far in the packet.
module router_pkt_lfsr_par
  import router_pkg::*;
#(
  parameter int LFSR_W = 8
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic              clear_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic [LFSR_W-1:0] hdr_i,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic [LFSR_W-1:0] lfsr_nxt_o,
  output logic [LFSR_W-1:0] par_nxt_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] par_q, par_d;

  assign lfsr_o     = lfsr_q;
  assign lfsr_nxt_o = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  // par_nxt_o folds in the byte currently on the bus, ready for the parity slot.
  assign par_nxt_o  = par_q ^ lfsr_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned and infers a latch.
    lfsr_d = lfsr_q;
    par_d  = par_q;
    if (clear_i) begin
      lfsr_d = '0;
      par_d  = '0;
    end else if (load_i) begin
      lfsr_d = (seed_i == '0) ? ZERO_SEED_SUB : seed_i;
      par_d  = hdr_i;
    end else if (advance_i) begin
      lfsr_d = lfsr_nxt_o;
      par_d  = par_nxt_o;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of block order.
    if (reset_i) begin
      lfsr_q <= '0;
      par_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      par_q  <= par_d;
    end
  end

endmodule

// File: rtl/router_pkt_gen.sv
// Header/payload/parity packet generator feeding a router port.
// Optional parity error injection: define ROUTER_PKT_GEN_ERR_INJ_EN.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int LFSR_W  = 8,  // only 8 is supported
  parameter int MAX_LEN = router_pkg::MAX_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        dest,
  input  logic [5:0]        len,
  input  logic [LFSR_W-1:0] seed,
  input  logic              busy,
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  input  logic              inject_err,
`endif
  output logic              packet_valid,
  output logic [LFSR_W-1:0] data_out,
  output logic              gen_busy,
  output logic              done,
  output logic              start_err
);

  state_e            state_q;
  logic [5:0]        cnt_q;
  logic [LFSR_W-1:0] data_out_q;
  logic              pv_q, gen_busy_q, done_q, start_err_q;

  logic              legal, load, advance, clear, inj_bit;
  logic [LFSR_W-1:0] hdr, lfsr, lfsr_nxt, par_nxt, par_byte;

  assign legal    = start_legal(dest, len, MAX_LEN);
  assign hdr      = {len, dest};
  assign load     = (state_q == ST_IDLE) && start && legal;
  assign advance  = (state_q == ST_PAYLOAD) && !busy;
  assign clear    = (state_q == ST_DONE);

`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  logic inj_q;
  always_ff @(posedge clk) begin
    if (reset)     inj_q <= 1'b0;
    else if (load) inj_q <= inject_err;
  end
  assign inj_bit = inj_q;
`else
  assign inj_bit = 1'b0;
`endif

  assign par_byte = par_nxt ^ {{(LFSR_W-1){1'b0}}, inj_bit};

  router_pkt_lfsr_par #(.LFSR_W(LFSR_W)) u_lfsr_par (
    .clk        (clk),
    .reset_i    (reset),
    .load_i     (load),
    .advance_i  (advance),
    .clear_i    (clear),
    .seed_i     (seed),
    .hdr_i      (hdr),
    .lfsr_o     (lfsr),
    .lfsr_nxt_o (lfsr_nxt),
    .par_nxt_o  (par_nxt)
  );

  // Outputs are registered alongside the state, so each state's byte is valid for its whole dwell.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_out_q  <= '0;
      pv_q        <= 1'b0;
      gen_busy_q  <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (legal) begin
              state_q    <= ST_HEADER;
              cnt_q      <= len;
              data_out_q <= hdr;
              pv_q       <= 1'b1;
              gen_busy_q <= 1'b1;
            end else begin
              start_err_q <= 1'b1;
            end
          end
        end
        ST_HEADER: begin
          if (!busy) begin
            state_q    <= ST_PAYLOAD;
            data_out_q <= lfsr;
          end
        end
        ST_PAYLOAD: begin
          if (!busy) begin
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
              state_q    <= ST_PARITY;
              data_out_q <= par_byte;
              pv_q       <= 1'b0;
            end else begin
              data_out_q <= lfsr_nxt;
            end
          end
        end
        ST_PARITY: begin
          if (!busy) begin
            state_q    <= ST_DONE;
            data_out_q <= '0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          gen_busy_q <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          gen_busy_q <= 1'b0;
          pv_q       <= 1'b0;
        end
      endcase
    end
  end

  assign packet_valid = pv_q;
  assign data_out     = data_out_q;
  assign gen_busy     = gen_busy_q;
  assign done         = done_q;
  assign start_err    = start_err_q;

endmodule
